pd_fetch_unit: RTL and testbench
================================

// Module: pd_fetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end; replaces the single-cycle PC/imem fetch stage.
//  Owns the PC and issues in-order requests to a variable-latency instruction memory.
//  Buffers fetched instructions in a DEPTH-entry reservation queue and presents them to decode over valid/ready.
//  Handles redirects (taken branch/jump, pcsel) by flushing the queue and discarding stale in-flight responses.
// PARAMETERS
//  BASEADDR  32'h01000000  PC value after reset
//  DEPTH     4             queue entries = max requests issued but not consumed; power of 2, >=2
//  AWIDTH    32            PC / address width
//  DWIDTH    32            instruction width
// PORTS
//  clk             in   1       clock, rising edge
//  reset           in   1       asynchronous, active-high reset
//  imem_req_valid  out  1       fetch request valid
//  imem_req_ready  in   1       memory accepts request
//  imem_req_addr   out  AWIDTH  fetch address
//  imem_rsp_valid  in   1       one-cycle response pulse, in request order, no backpressure
//  imem_rsp_data   in   DWIDTH  instruction word
//  redirect_valid  in   1       pcsel from execute: flush and restart
//  redirect_pc     in   AWIDTH  new PC
//  dec_valid       out  1       head entry filled, presented to decode
//  dec_ready       in   1       decode consumes head
//  dec_pc          out  AWIDTH  PC of head entry (0 when !dec_valid)
//  dec_insn        out  DWIDTH  instruction of head entry (0 when !dec_valid)
// BEHAVIOUR
//  - Reset: pc_q=BASEADDR, state=IDLE, all pointers/drop_cnt=0, every output 0.
//  - FSM IDLE->FETCH unconditionally one cycle after reset deasserts.
//  - FETCH->DRAIN on redirect when stale requests remain (see drop_cnt); DRAIN->FETCH when drop_cnt reaches 0.
//  - Queue pointers alloc/fill/rd are log2(DEPTH)+1 bits. count=alloc-rd; outstanding=alloc-fill.
//  - Request: in FETCH, imem_req_valid=1 iff count<DEPTH and !redirect_valid; imem_req_addr=pc_q.
//  - Address stays stable while valid&&!ready. On accept: slot[alloc].pc=pc_q, alloc++, pc_q+=4 (mod 2^AWIDTH).
//  - Response: if drop_cnt>0, discard and decrement drop_cnt. Otherwise write slot[fill].insn, mark filled, fill++.
//  - Decode: dec_valid = count>0 && slot[rd].filled && !redirect_valid. Pop on dec_valid&&dec_ready: clear filled, rd++.
//  - Latency: zero-wait memory (ready=1, rsp next cycle) -> dec_valid 2 cycles after request issue; sustained 1 insn/cycle.
//  - Redirect has priority over all same-cycle events:
//    - pc_q<=redirect_pc with bits[1:0] forced 00; alloc/fill/rd<=0; all filled bits cleared; no pop.
//    - drop_cnt<=outstanding+drop_cnt-(imem_rsp_valid). The redirect-cycle request is never issued (req_valid=0).
//    - Next state is DRAIN if the new drop_cnt>0, else FETCH.
//  - DRAIN: no requests issued; redirect in DRAIN accumulates drop_cnt by the same rule.
//  - Full (count==DEPTH): req_valid=0 until a pop. Empty or head unfilled: dec_valid=0.
//  - Pop and accept in the same cycle when full is legal; the freed slot is reused next cycle.
// CONFIGURATION
//  PD_FETCH_PERF_EN defined: adds outputs perf_fetched[31:0] (+1 per pop) and perf_dropped[31:0] (+1 per discarded rsp).
//    Both counters are reset to 0 and saturate at 32'hFFFFFFFF.
//  PD_FETCH_PERF_EN undefined: ports and counters are absent; no other behaviour changes.
// STRUCTURE
//  pd_fetch_pkg holds:
//    - fetch_state_e {IDLE,FETCH,DRAIN}
//    - fetch_entry_t {pc, insn, filled}
//    - PD_BASEADDR_DEFAULT, PD_INSN_BYTES=4
//  Sub-module pd_fetch_queue holds the reservation queue: alloc/fill/pop/flush ports, count/outstanding/head outputs.
//  pd_fetch_unit keeps the FSM, PC and drop_cnt.
// TESTING
//  - Reset, ready=1, 1-cycle rsp fd010113 -> first req addr 01000000; dec_pc=01000000 dec_insn=fd010113.
//  - Streaming, dec_ready=1 -> req addrs 01000000,04,08,... one per cycle; dec_valid held 1.
//  - dec_ready=0, DEPTH=4 -> exactly 4 accepts (01000000..0C), then req_valid=0.
//    Raise dec_ready -> one new req per pop, addr 01000010 first.
//  - Redirect to 01000100 with 2 outstanding -> state DRAIN, next 2 rsps dropped, dec_valid=0.
//    Then first req addr 01000100 and its insn reaches dec.
//  - Redirect in same cycle as req accept and rsp arrival, 1 prior outstanding:
//    drop_cnt=1+... per rule, redirect-cycle req_valid=0, no stale insn reaches decode.
//  - Redirect to fffffffc, then two accepts -> addrs fffffffc, 00000000 (wrap).
//    Also redirect_pc 01000102 -> req addr 01000100.

Source files
------------

// File: rtl/pd_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// No logic of its own; the latency and backpressure of each block are described in that block's file.
// The entry layout below is the queue slot for the default 32-bit PC and instruction widths.
package pd_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        filled;
    } fetch_entry_t;

    localparam logic [31:0] PD_BASEADDR_DEFAULT = 32'h0100_0000;
    localparam int          PD_INSN_BYTES       = 4;

endpackage

// File: rtl/pd_fetch_queue.sv
// Reservation queue: slots are allocated at request accept and filled in order as responses return.
// Head fields are combinational from state; a fill becomes visible at the head one cycle after it is written.
// The caller stalls allocation on count==DEPTH; flush empties every slot and wins over alloc/fill/pop.
module pd_fetch_queue
    import pd_fetch_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter int  AWIDTH = 32,
    parameter int  DWIDTH = 32,
    localparam int IW     = $clog2(DEPTH),
    localparam int PW     = IW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_vld,
    input  logic [AWIDTH-1:0] alloc_pc,
    input  logic              fill_vld,
    input  logic [DWIDTH-1:0] fill_insn,
    input  logic              pop_vld,
    input  logic              flush,
    output logic [PW-1:0]     count,
    output logic [PW-1:0]     outstanding,
    output logic              head_vld,
    output logic [AWIDTH-1:0] head_pc,
    output logic [DWIDTH-1:0] head_insn
);

    // One extra pointer bit distinguishes full from empty.
    logic [PW-1:0]     alloc_ptr;
    logic [PW-1:0]     fill_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DEPTH-1:0]  filled;
    logic [AWIDTH-1:0] pc_mem   [DEPTH];
    logic [DWIDTH-1:0] insn_mem [DEPTH];

    // Pointers and filled flags; flush returns the queue to its empty state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            filled    <= '0;
        end else if (flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            filled    <= '0;
        end else begin
            if (alloc_vld) begin
                alloc_ptr <= alloc_ptr + PW'(1);
            end
            if (fill_vld) begin
                filled[fill_ptr[IW-1:0]] <= 1'b1;
                fill_ptr                 <= fill_ptr + PW'(1);
            end
            // A filled head can never be the fill target, so these two never touch the same bit.
            if (pop_vld) begin
                filled[rd_ptr[IW-1:0]] <= 1'b0;
                rd_ptr                 <= rd_ptr + PW'(1);
            end
        end
    end

    // Slot payloads need no reset: they are only read behind the filled flag.
    always_ff @(posedge clk) begin
        if (alloc_vld && !flush) begin
            pc_mem[alloc_ptr[IW-1:0]] <= alloc_pc;
        end
        if (fill_vld && !flush) begin
            insn_mem[fill_ptr[IW-1:0]] <= fill_insn;
        end
    end

    assign count       = alloc_ptr - rd_ptr;
    assign outstanding = alloc_ptr - fill_ptr;
    assign head_vld    = (count != '0) && filled[rd_ptr[IW-1:0]];
    assign head_pc     = pc_mem[rd_ptr[IW-1:0]];
    assign head_insn   = insn_mem[rd_ptr[IW-1:0]];

endmodule

// File: rtl/pd_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order imem requests and queues results for decode.
// A zero-wait memory gives dec_valid two cycles after request issue, with a sustained rate of one insn per cycle.
// Requests stall when the queue is full or while stale responses drain; decode holds the head with dec_ready.
// Optional PD_FETCH_PERF_EN adds saturating perf_fetched/perf_dropped counters.
module pd_fetch_unit
    import pd_fetch_pkg::*;
#(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(PD_BASEADDR_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [AWIDTH-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DWIDTH-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [AWIDTH-1:0] dec_pc,
    output logic [DWIDTH-1:0] dec_insn
`ifdef PD_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_dropped
`endif
);

    localparam int            PW      = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [AWIDTH-1:0] pc_q;
    logic [PW-1:0]     drop_cnt_q;
    logic [PW-1:0]     drop_cnt_d;
    logic [PW-1:0]     q_count;
    logic [PW-1:0]     q_outstanding;
    logic              q_head_vld;
    logic [AWIDTH-1:0] q_head_pc;
    logic [DWIDTH-1:0] q_head_insn;
    logic              req_fire;
    logic              rsp_keep;
    logic              pop_vld;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign pop_vld  = dec_valid && dec_ready;
    // A response is kept only when nothing stale is ahead of it and no flush is happening.
    assign rsp_keep = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stale-response count: a redirect turns every in-flight request into one to discard.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            drop_cnt_d = drop_cnt_q + q_outstanding - PW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - PW'(1);
        end
    end

    // Next state: stay in DRAIN exactly while stale responses remain.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:         state_d = FETCH;
            FETCH, DRAIN: state_d = (drop_cnt_d != '0) ? DRAIN : FETCH;
            default:      state_d = IDLE;
        endcase
    end

    // Outputs; addresses and decode fields read as zero whenever their valid is low.
    always_comb begin
        imem_req_valid = (state_q == FETCH) && (q_count < DEPTH_P) && !redirect_valid;
        imem_req_addr  = imem_req_valid ? pc_q : '0;
        dec_valid      = q_head_vld && !redirect_valid;
        dec_pc         = dec_valid ? q_head_pc : '0;
        dec_insn       = dec_valid ? q_head_insn : '0;
    end

    // PC and drop counter; a redirect target is forced to instruction alignment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= BASEADDR;
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            if (redirect_valid) begin
                pc_q <= redirect_pc & ~AWIDTH'(PD_INSN_BYTES - 1);
            end else if (req_fire) begin
                pc_q <= pc_q + AWIDTH'(PD_INSN_BYTES);
            end
        end
    end

    pd_fetch_queue #(
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .alloc_vld   (req_fire),
        .alloc_pc    (pc_q),
        .fill_vld    (rsp_keep),
        .fill_insn   (imem_rsp_data),
        .pop_vld     (pop_vld),
        .flush       (redirect_valid),
        .count       (q_count),
        .outstanding (q_outstanding),
        .head_vld    (q_head_vld),
        .head_pc     (q_head_pc),
        .head_insn   (q_head_insn)
    );

`ifdef PD_FETCH_PERF_EN
    // Saturating event counters: instructions handed to decode and responses thrown away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (pop_vld && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (imem_rsp_valid && !rsp_keep && (perf_dropped != '1)) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pd_fetch_unit.sv
// Bench for pd_fetch_unit: directed scenarios plus a queue-level reference model checked every cycle.
// The memory model answers each accepted request after a programmable fixed latency.
// Decode backpressure and redirects are driven by the directed sequence.
module tb_pd_fetch_unit;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int          DEPTH = 4;

    logic        clk            = 1'b0;
    logic        reset          = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        dec_valid;
    logic        dec_ready      = 1'b0;
    logic [31:0] dec_pc;
    logic [31:0] dec_insn;
`ifdef PD_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pd_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_insn       (dec_insn)
`ifdef PD_FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == BASE) return 32'hfd01_0113;
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];
    int    cyc     = 0;
    int    lat     = 1;
    int    acc_cnt = 0;

    always @(posedge clk) begin
        if (reset) begin
            pend.delete();
            cyc     = 0;
            acc_cnt = 0;
        end else begin
            cyc++;
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{addr: imem_req_addr, due: cyc + lat - 1});
                acc_cnt++;
            end
        end
        #1;
        if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
            pend.delete(0);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    // ---------------- reference model ----------------
    // The front end is an ordered list of requested instructions, each either awaiting
    // its word or holding it, plus a number of responses still owed to discarded requests.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        bit          filled;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc      = BASE;
    int          m_drop    = 0;
    bit          m_started = 1'b0;

    function automatic int n_unfilled();
        int n = 0;
        foreach (mq[i]) if (!mq[i].filled) n++;
        return n;
    endfunction

    function automatic bit exp_req_valid();
        return m_started && (m_drop == 0) && (mq.size() < DEPTH) && !redirect_valid;
    endfunction

    function automatic bit exp_dec_valid();
        if (mq.size() == 0) return 1'b0;
        return mq[0].filled && !redirect_valid;
    endfunction

    always @(posedge clk) begin : model
        bit   rv;
        bit   dv;
        int   idx;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_pc      = BASE;
            m_drop    = 0;
            m_started = 1'b0;
        end else begin
            rv = exp_req_valid();
            dv = exp_dec_valid();
            if (redirect_valid) begin
                m_drop = m_drop + n_unfilled() - (imem_rsp_valid ? 1 : 0);
                mq.delete();
                m_pc = redirect_pc & 32'hffff_fffc;
            end else begin
                if (dv && dec_ready) mq.delete(0);
                if (imem_rsp_valid) begin
                    if (m_drop > 0) begin
                        m_drop--;
                    end else begin
                        idx = -1;
                        foreach (mq[i]) if (idx < 0 && !mq[i].filled) idx = i;
                        if (idx >= 0) begin
                            e        = mq[idx];
                            e.insn   = imem_rsp_data;
                            e.filled = 1'b1;
                            mq[idx]  = e;
                        end
                    end
                end
                if (rv && imem_req_ready) begin
                    mq.push_back('{pc: m_pc, insn: 32'h0, filled: 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
            m_started = 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("cyc req_valid", 32'(imem_req_valid), 32'(exp_req_valid()));
            if (exp_req_valid()) check("cyc req_addr", imem_req_addr, m_pc);
            check("cyc dec_valid", 32'(dec_valid), 32'(exp_dec_valid()));
            check("cyc dec_pc", dec_pc, exp_dec_valid() ? mq[0].pc : 32'h0);
            check("cyc dec_insn", dec_insn, exp_dec_valid() ? mq[0].insn : 32'h0);
        end
    end

    // ---------------- directed sequence ----------------
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic quiesce();
        imem_req_ready = 1'b0;
        dec_ready      = 1'b1;
        repeat (8) tick();
        check("quiesce dec_valid", 32'(dec_valid), 32'd0);
    endtask

    task automatic wait_dec(input int n, input logic [31:0] epc, input logic [31:0] einsn, input string nm);
        int k = 0;
        while (!dec_valid && k < n) begin
            tick();
            k++;
        end
        if (!dec_valid) begin
            n_total++;
            n_bad++;
            $display("FAIL %s timeout: dec_valid=0 after %0d cycles, required 1", nm, n);
        end else begin
            check({nm, " dec_pc"}, dec_pc, epc);
            check({nm, " dec_insn"}, dec_insn, einsn);
        end
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b0;
        lat            = 1;
        repeat (3) tick();
        check("reset req_valid", 32'(imem_req_valid), 32'd0);
        check("reset req_addr", imem_req_addr, 32'h0);
        check("reset dec_valid", 32'(dec_valid), 32'd0);
        check("reset dec_pc", dec_pc, 32'h0);
        check("reset dec_insn", dec_insn, 32'h0);

        // First fetch and its latency to decode, decode held off.
        reset = 1'b0;
        tick();
        check("first req_valid", 32'(imem_req_valid), 32'd1);
        check("first req_addr", imem_req_addr, 32'h0100_0000);
        check("first dec_valid", 32'(dec_valid), 32'd0);
        tick();
        check("second req_addr", imem_req_addr, 32'h0100_0004);
        tick();
        check("first dec_valid 2cyc", 32'(dec_valid), 32'd1);
        check("first dec_pc", dec_pc, 32'h0100_0000);
        check("first dec_insn", dec_insn, 32'hfd01_0113);

        // Queue fills to DEPTH, then requests stop.
        tick();
        tick();
        check("full req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        check("full req_valid held", 32'(imem_req_valid), 32'd0);
        check("full accept count", 32'(acc_cnt), 32'd4);

        // Releasing decode: one request per pop, then a steady stream.
        dec_ready = 1'b1;
        tick();
        check("refill req_valid", 32'(imem_req_valid), 32'd1);
        check("refill req_addr", imem_req_addr, 32'h0100_0010);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("stream req_addr", imem_req_addr, 32'h0100_0010 + 32'(4 * i));
            check("stream dec_valid", 32'(dec_valid), 32'd1);
        end

        // Redirect with two requests in flight.
        quiesce();
        lat            = 3;
        imem_req_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0100;
        #1;
        check("redir cycle req_valid", 32'(imem_req_valid), 32'd0);
        check("redir cycle dec_valid", 32'(dec_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("drain req_valid", 32'(imem_req_valid), 32'd0);
        check("drain dec_valid", 32'(dec_valid), 32'd0);
        tick();
        check("drain req_valid 2", 32'(imem_req_valid), 32'd0);
        check("drain dec_valid 2", 32'(dec_valid), 32'd0);
        tick();
        check("post drain req_valid", 32'(imem_req_valid), 32'd1);
        check("post drain req_addr", imem_req_addr, 32'h0100_0100);
        wait_dec(12, 32'h0100_0100, mem_word(32'h0100_0100), "redirect target");

        // Redirect coinciding with a response, an offered request and one other outstanding.
        quiesce();
        lat            = 2;
        imem_req_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0200;
        #1;
        check("coinc redir req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("coinc drain req_valid", 32'(imem_req_valid), 32'd0);
        check("coinc drain dec_valid", 32'(dec_valid), 32'd0);
        tick();
        check("coinc restart req_valid", 32'(imem_req_valid), 32'd1);
        check("coinc restart req_addr", imem_req_addr, 32'h0100_0200);
        wait_dec(12, 32'h0100_0200, mem_word(32'h0100_0200), "coinc target");

        // PC wrap and target alignment.
        quiesce();
        lat            = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hffff_fffc;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        check("wrap req_valid", 32'(imem_req_valid), 32'd1);
        check("wrap req_addr 0", imem_req_addr, 32'hffff_fffc);
        tick();
        check("wrap req_addr 1", imem_req_addr, 32'h0000_0000);
        imem_req_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0102;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        check("align req_valid", 32'(imem_req_valid), 32'd1);
        check("align req_addr", imem_req_addr, 32'h0100_0100);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
